// File: rtl/morse_pkg.sv
// Shared definitions for the Morse playback controller.
//   Symbol codes, FSM state encoding, unit lengths and a small symbol helper.
package morse_pkg;

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_RSV  = 2'b11;

  // Lengths in Morse time units.
  localparam logic [1:0] DOT_U  = 2'd1;
  localparam logic [1:0] DASH_U = 2'd3;
  localparam logic [1:0] GAP_U  = 2'd1;
  localparam logic [1:0] LGAP_U = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTone = 2'd1,
    StGap  = 2'd2,
    StLgap = 2'd3
  } state_e;

  // Both the end code and the reserved code terminate a letter.
  function automatic logic sym_is_end(input logic [1:0] sym);
    return (sym == SYM_END) || (sym == SYM_RSV);
  endfunction

  // Tone length of a symbol that is known not to be an end code.
  function automatic logic [1:0] sym_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer.
//   Emits a one-cycle unit_tick every TICK_DIV cycles, counted from the last restart.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   restart   zero the count at the next edge (asserted on every FSM state entry)
//   unit_tick high during the last cycle of each unit
module morse_unit_timer #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic unit_tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign unit_tick = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart || unit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/morse_seq_ctrl.sv
// Morse playback controller.
//   Accepts a 10-bit letter (five 2-bit symbols, MSB pair first) over start/ready and plays it
//   on tone with dot/dash/gap timing; exports a 4-bit completed-letter counter.
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start, pattern  letter request and pattern, taken when start && ready
//   ready           combinational from state registers
//   busy, tone      registered: letter playing / audio enable
//   done            registered one-cycle pulse on letter completion
//   letters         registered count of completed letters (mod 16)
// Configuration:
//   MORSE_SEQ_QUEUE_EN  adds a one-entry pending letter buffer
module morse_seq_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] pattern,
  output logic       ready,
  output logic       busy,
  output logic       tone,
  output logic       done,
  output logic [3:0] letters
);

  state_e     state_q, state_d;
  logic [9:0] sreg_q, sreg_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] ucnt_q, ucnt_d;
  logic       tone_q, busy_q, done_q, done_d;
  logic [3:0] letters_q, letters_d;
  logic       restart, unit_tick, accept;
  logic       load;
  logic [9:0] load_pat;

`ifdef MORSE_SEQ_QUEUE_EN
  logic [9:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  assign ready = !busy_q || !pend_vld_q;
`else
  assign ready = !busy_q;
`endif

  assign accept  = start && ready;
  assign busy    = busy_q;
  assign tone    = tone_q;
  assign done    = done_q;
  assign letters = letters_q;

  morse_unit_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .unit_tick (unit_tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    ucnt_d    = ucnt_q;
    done_d    = 1'b0;
    letters_d = letters_q;
    restart   = 1'b0;
    load      = 1'b0;
    load_pat  = pattern;
`ifdef MORSE_SEQ_QUEUE_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef MORSE_SEQ_QUEUE_EN
        // A letter left in the buffer (only an empty one can be) is drained first.
        if (pend_vld_q) begin
          load       = 1'b1;
          load_pat   = pend_q;
          pend_vld_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end
`else
        if (accept) begin
          load = 1'b1;
        end
`endif
      end
      StTone: begin
        if (unit_tick) begin
          if (ucnt_q == sym_units(sreg_q[9:8]) - 2'd1) begin
            ucnt_d  = '0;
            restart = 1'b1;
            if (idx_q == 3'd4 || sym_is_end(sreg_q[7:6])) begin
              state_d = StLgap;
            end else begin
              state_d = StGap;
            end
          end else begin
            ucnt_d = ucnt_q + 2'd1;
          end
        end
      end
      StGap: begin
        if (unit_tick) begin
          if (ucnt_q == GAP_U - 2'd1) begin
            ucnt_d  = '0;
            restart = 1'b1;
            sreg_d  = {sreg_q[7:0], 2'b00};
            idx_d   = idx_q + 3'd1;
            state_d = StTone;
          end else begin
            ucnt_d = ucnt_q + 2'd1;
          end
        end
      end
      StLgap: begin
        if (unit_tick) begin
          if (ucnt_q == LGAP_U - 2'd1) begin
            ucnt_d    = '0;
            restart   = 1'b1;
            done_d    = 1'b1;
            letters_d = letters_q + 4'd1;
            state_d   = StIdle;
`ifdef MORSE_SEQ_QUEUE_EN
            // Chain straight into a buffered letter; an empty one waits for IDLE so that
            // its own done pulse does not collide with this one.
            if (pend_vld_q && !sym_is_end(pend_q[9:8])) begin
              load       = 1'b1;
              load_pat   = pend_q;
              pend_vld_d = 1'b0;
            end
`endif
          end else begin
            ucnt_d = ucnt_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      sreg_d  = load_pat;
      idx_d   = '0;
      ucnt_d  = '0;
      restart = 1'b1;
      if (sym_is_end(load_pat[9:8])) begin
        state_d   = StIdle;
        done_d    = 1'b1;
        letters_d = letters_q + 4'd1;
      end else begin
        state_d = StTone;
      end
    end

`ifdef MORSE_SEQ_QUEUE_EN
    // Anything accepted that did not go straight into the shift register is buffered.
    if (accept && !(load && load_pat == pattern && !(state_q == StIdle && pend_vld_q)
                    && state_q == StIdle)) begin
      pend_d     = pattern;
      pend_vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      idx_q     <= '0;
      ucnt_q    <= '0;
      tone_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      letters_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      ucnt_q    <= ucnt_d;
      tone_q    <= (state_d == StTone);
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
      letters_q <= letters_d;
    end
  end

`ifdef MORSE_SEQ_QUEUE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_morse_seq_ctrl.sv
module tb_morse_seq_ctrl;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] pattern;
  logic       ready, busy, tone, done;
  logic [3:0] letters;

  morse_seq_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .ready   (ready),
    .busy    (busy),
    .tone    (tone),
    .done    (done),
    .letters (letters)
  );

  always #5 clk = ~clk;

  typedef struct {
    int done_cyc;
    int tone_cyc;
    int letters;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tone_cnt = 0;
  int   exp_letters = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference timing: n symbols totalling u units, each unit TD cycles.
  task automatic model(input logic [9:0] p, output int dur, output int tcyc);
    int u = 0;
    int n = 0;
    logic [1:0] s;
    for (int i = 0; i < 5; i++) begin
      s = p[9-2*i -: 2];
      if (s == 2'b00 || s == 2'b11) break;
      u += (s == 2'b10) ? 3 : 1;
      n++;
    end
    tcyc = u * TD;
    dur  = (n == 0) ? 1 : 1 + (u + (n - 1) + 3) * TD;
  endtask

  // Scoreboard: each done pulse pops an entry; tone cycles are counted between done pulses.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      tone_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check_val("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.done_cyc);
        check_val("tone_cycles", tone_cnt, e.tone_cyc);
        check_val("letters", {28'd0, letters}, e.letters);
      end
      tone_cnt = tone ? 1 : 0;
    end else begin
      tone_cnt += tone ? 1 : 0;
    end
  end

  // Drives one handshake from idle; returns at the negedge of relative cycle 1.
  task automatic send(input logic [9:0] p, output int t0);
    int dur, tcyc;
    @(negedge clk);
    check_val("ready_before_send", {31'd0, ready}, 32'd1);
    start   = 1'b1;
    pattern = p;
    t0      = cyc;
    model(p, dur, tcyc);
    exp_letters = (exp_letters + 1) % 16;
    sb.push_back('{done_cyc: t0 + dur, tone_cyc: tcyc, letters: exp_letters});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t0;
    int dur, tcyc;
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    repeat (2) @(negedge clk);
    check_val("rst_tone", {31'd0, tone}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_letters", {28'd0, letters}, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single dot with directed tone edges.
    send(10'b01_00_00_00_00, t0);
    check_val("dot_tone_c1", {31'd0, tone}, 32'd1);
    check_val("dot_busy_c1", {31'd0, busy}, 32'd1);
    check_val("dot_ready_c1", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("dot_tone_c4", {31'd0, tone}, 32'd1);
    @(negedge clk);
    check_val("dot_tone_c5", {31'd0, tone}, 32'd0);
    check_val("dot_busy_c5", {31'd0, busy}, 32'd1);
    drain();

    // Dash-dot.
    send(10'b10_01_00_00_00, t0);
    repeat (11) @(negedge clk);
    check_val("dd_tone_c12", {31'd0, tone}, 32'd1);
    @(negedge clk);
    check_val("dd_tone_c13", {31'd0, tone}, 32'd0);
    repeat (4) @(negedge clk);
    check_val("dd_tone_c17", {31'd0, tone}, 32'd1);
    drain();

    // Full five-dot letter, then reserved code terminating after one dot.
    send(10'b01_01_01_01_01, t0);
    drain();
    send(10'b01_11_01_00_00, t0);
    drain();

    // Empty letter: done next cycle, never busy.
    send(10'b00_00_00_00_00, t0);
    check_val("empty_done_c1", {31'd0, done}, 32'd1);
    check_val("empty_busy_c1", {31'd0, busy}, 32'd0);
    check_val("empty_tone_c1", {31'd0, tone}, 32'd0);
    check_val("empty_ready_c1", {31'd0, ready}, 32'd1);
    drain();

    // Second letter offered at cycle 8 while busy.
    send(10'b01_00_00_00_00, t0);
    repeat (7) @(negedge clk);
`ifdef MORSE_SEQ_QUEUE_EN
    check_val("q_ready_c8", {31'd0, ready}, 32'd1);
    model(10'b01_00_00_00_00, dur, tcyc);
    exp_letters = (exp_letters + 1) % 16;
    sb.push_back('{done_cyc: t0 + 17 + dur - 1, tone_cyc: tcyc, letters: exp_letters});
`else
    check_val("q_ready_c8", {31'd0, ready}, 32'd0);
`endif
    start   = 1'b1;
    pattern = 10'b01_00_00_00_00;
    @(negedge clk);
    start = 1'b0;
    check_val("q_ready_c9", {31'd0, ready}, 32'd0);
    repeat (7) @(negedge clk);
    check_val("q_ready_c16", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check_val("q_done_c17", {31'd0, done}, 32'd1);
    check_val("q_ready_c17", {31'd0, ready}, 32'd1);
`ifdef MORSE_SEQ_QUEUE_EN
    check_val("q_tone_c17", {31'd0, tone}, 32'd1);
    check_val("q_busy_c17", {31'd0, busy}, 32'd1);
`else
    check_val("q_tone_c17", {31'd0, tone}, 32'd0);
    check_val("q_busy_c17", {31'd0, busy}, 32'd0);
`endif
    drain();

    // Reset in the middle of a dash.
    send(10'b10_00_00_00_00, t0);
    repeat (5) @(negedge clk);
    check_val("rstmid_tone_c6", {31'd0, tone}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("rstmid_tone_async", {31'd0, tone}, 32'd0);
    sb.delete();
    exp_letters = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rstmid_busy", {31'd0, busy}, 32'd0);
    check_val("rstmid_ready", {31'd0, ready}, 32'd1);
    check_val("rstmid_letters", {28'd0, letters}, 32'd0);
    check_val("rstmid_done", {31'd0, done}, 32'd0);

    // Recovery after reset.
    send(10'b01_00_00_00_00, t0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
